car_motion_controller: RTL

//  Sequences the single car of the 2-way, 7-floor elevator: owns currentFloor, currentDirection,

---
 rtl/car_motion_controller.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/car_motion_controller.sv
// car_motion_controller
// Sequences the single car of a 2-way, 7-floor elevator: floor-to-floor travel timing,
// stop/pass decision at each floor, door dwell, and one-cycle clear strobes back to the
// hall and car button latches. All outputs are registered.
// Optional feature: define CAR_ESTOP_EN to add an active-high estop input that freezes
// motion and timers in place until released.
module car_motion_controller #(
    parameter int TRAVEL_CYCLES = 100,
    parameter int DOOR_CYCLES   = 200,
    parameter int CNT_W         = 16
) (
    input  logic        clk,
    input  logic        reset,
`ifdef CAR_ESTOP_EN
    input  logic        estop,
`endif
    input  logic [1:0]  nextDirection,
    input  logic [13:0] floorButton,
    input  logic [9:1]  internalButton,
    output logic [2:0]  currentFloor,
    output logic [1:0]  currentDirection,
    output logic        doorState,
    output logic        move,
    output logic [13:0] clearFloor,
    output logic [7:1]  clearInternal
);

    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b10;
    localparam logic [1:0] DIR_DOWN = 2'b01;
    localparam logic [CNT_W-1:0] TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);

    typedef enum logic [2:0] {SETTLE, IDLE, MOVE, ARRIVE, OPEN} stateType;

    stateType         state, stateNxt;
    logic [CNT_W-1:0] timer, timerNxt;
    logic [2:0]       floorNxt;
    logic [1:0]       dirNxt;
    logic             doorNxt, moveNxt;
    logic [13:0]      clearFloorNxt;
    logic [7:1]       clearInternalNxt;
    logic [2:0]       herePrev;       // {car, hallUp, hallDown} at this floor, last cycle

    logic carHere, hallUpHere, hallDownHere, here, reqAbove, reqBelow;
    logic atTop, atBottom, endFloor, wantUp, wantDown, openBtn, closeBtn;
    logic [2:0]  hereVec;
    logic        newHere, timerZero, stopHere, openEntry, openReload, frozen;
    logic [1:0]  clrDir;
    logic [13:0] hallClr;
    logic [7:1]  carClr;

`ifdef CAR_ESTOP_EN
    assign frozen = estop;
`else
    assign frozen = 1'b0;
`endif

    assign here      = carHere | hallUpHere | hallDownHere;
    assign hereVec   = {carHere, hallUpHere, hallDownHere};
    // Only freshly raised requests reload the door; a still-latched one must not keep it open
    assign newHere   = |(hereVec & ~herePrev);
    assign atTop     = (currentFloor == 3'd7);
    assign atBottom  = (currentFloor == 3'd1);
    assign endFloor  = atTop | atBottom;
    assign wantUp    = (nextDirection == DIR_UP);
    assign wantDown  = (nextDirection == DIR_DOWN);
    assign openBtn   = internalButton[8];
    assign closeBtn  = internalButton[9];
    assign timerZero = (timer == '0);
    // Opening from IDLE serves the floor with no travel direction, so both hall calls clear
    assign clrDir    = (state == IDLE) ? DIR_STOP : currentDirection;

    // Requests at the current floor and anywhere above / below it
    always_comb begin
        carHere      = 1'b0;
        hallUpHere   = 1'b0;
        hallDownHere = 1'b0;
        reqAbove     = 1'b0;
        reqBelow     = 1'b0;
        for (int f = 1; f <= 7; f++) begin
            if (int'(currentFloor) == f) begin
                carHere      = internalButton[f];
                hallUpHere   = floorButton[2*f-2];
                hallDownHere = floorButton[2*f-1];
            end else if (f > int'(currentFloor)) begin
                reqAbove = reqAbove | internalButton[f] | floorButton[2*f-2] | floorButton[2*f-1];
            end else begin
                reqBelow = reqBelow | internalButton[f] | floorButton[2*f-2] | floorButton[2*f-1];
            end
        end
    end

    // Clear strobes for serving the current floor in the current direction
    always_comb begin
        carClr  = '0;
        hallClr = '0;
        for (int f = 1; f <= 7; f++) begin
            if (int'(currentFloor) == f) begin
                carClr[f] = 1'b1;
                if (clrDir == DIR_UP && !endFloor) begin
                    hallClr[2*f-2] = 1'b1;
                end else if (clrDir == DIR_DOWN && !endFloor) begin
                    hallClr[2*f-1] = 1'b1;
                end else begin
                    hallClr[2*f-2] = 1'b1;
                    hallClr[2*f-1] = 1'b1;
                end
            end
        end
    end

    // Stop decision on arrival; an opposite-direction hall call alone never stops the car
    always_comb begin
        if (currentDirection == DIR_UP) begin
            stopHere = carHere | hallUpHere | atTop | ~reqAbove;
        end else if (currentDirection == DIR_DOWN) begin
            stopHere = carHere | hallDownHere | atBottom | ~reqBelow;
        end else begin
            stopHere = 1'b1;
        end
    end

    assign openEntry  = (state != OPEN) && (stateNxt == OPEN);
    assign openReload = (state == OPEN) && !frozen && (openBtn || newHere);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= SETTLE;
        else        state <= stateNxt;
    end

    // Next-state logic
    always_comb begin
        stateNxt = state;
        case (state)
            SETTLE: stateNxt = IDLE;
            IDLE: begin
                if (!frozen) begin
                    if (here)                       stateNxt = OPEN;
                    else if (wantUp && !atTop)      stateNxt = MOVE;
                    else if (wantDown && !atBottom) stateNxt = MOVE;
                end
            end
            MOVE:   if (!frozen && timerZero) stateNxt = ARRIVE;
            ARRIVE: if (!frozen) stateNxt = stopHere ? OPEN : MOVE;
            OPEN:   if (!frozen && !openReload && (closeBtn || timerZero)) stateNxt = SETTLE;
            default: stateNxt = SETTLE;
        endcase
    end

    // Next values of the registered outputs and the shared timer
    always_comb begin
        floorNxt         = currentFloor;
        dirNxt           = currentDirection;
        timerNxt         = timer;
        doorNxt          = (stateNxt == OPEN);
        moveNxt          = (stateNxt == MOVE) && !frozen;
        clearFloorNxt    = '0;
        clearInternalNxt = '0;
        case (state)
            IDLE: begin
                if (!frozen) begin
                    if (here) begin
                        dirNxt = DIR_STOP;
                    end else if (wantUp && !atTop) begin
                        dirNxt   = DIR_UP;
                        timerNxt = TRAVEL_LOAD;
                    end else if (wantDown && !atBottom) begin
                        dirNxt   = DIR_DOWN;
                        timerNxt = TRAVEL_LOAD;
                    end else begin
                        dirNxt = DIR_STOP;
                    end
                end
            end
            MOVE: begin
                if (!frozen) begin
                    if (timerZero)
                        floorNxt = (currentDirection == DIR_UP) ? currentFloor + 3'd1
                                                                : currentFloor - 3'd1;
                    else
                        timerNxt = timer - CNT_W'(1);
                end
            end
            ARRIVE: if (!frozen && !stopHere) timerNxt = TRAVEL_LOAD;
            OPEN: begin
                if (!frozen) begin
                    if (openReload)      timerNxt = DOOR_LOAD;
                    else if (closeBtn)   timerNxt = '0;
                    else if (!timerZero) timerNxt = timer - CNT_W'(1);
                end
            end
            default: ;
        endcase
        if (openEntry || openReload) begin
            timerNxt         = DOOR_LOAD;
            clearFloorNxt    = hallClr;
            clearInternalNxt = carClr;
        end
    end

    // Output, timer and request-snapshot registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            currentFloor     <= 3'd1;
            currentDirection <= DIR_STOP;
            doorState        <= 1'b0;
            move             <= 1'b0;
            clearFloor       <= '0;
            clearInternal    <= '0;
            timer            <= '0;
            herePrev         <= '0;
        end else begin
            currentFloor     <= floorNxt;
            currentDirection <= dirNxt;
            doorState        <= doorNxt;
            move             <= moveNxt;
            clearFloor       <= clearFloorNxt;
            clearInternal    <= clearInternalNxt;
            timer            <= timerNxt;
            herePrev         <= hereVec;
        end
    end

endmodule
